qspi_rom_arbiter: RTL and testbench
===================================

Name: qspi_rom_arbiter

Overview:
- Sequences single-byte quad-I/O reads from the external QSPI flash and shares the flash between two requesters.
- Port A is the cartridge-ROM fetch path; port B is the secondary path (bank preload/debug).
- Sits between the console core and the flash pins.
- Drives SCLK, chip-select, and per-pin output enables for the top-level tristate buffers.

Parameters:
- CMD, 8'hEB, read opcode, sent as 2 nibbles, high nibble first.
- DUMMY_CYCLES, 6, SCLK periods with bus released between address and data; legal range 0..15.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- req_a  in  1  port A read request, held until ack_a
- addr_a  in  24  port A byte address, stable while req_a is high
- ack_a  out  1  one-cycle pulse; rdata valid for port A
- req_b  in  1  port B read request, held until ack_b
- addr_b  in  24  port B byte address
- ack_b  out  1  one-cycle pulse; rdata valid for port B
- rdata  out  8  last byte read; held until the next transaction completes
- busy  out  1  high whenever state != IDLE
- qspi_sclk  out  1  flash clock
- qspi_cs_n  out  1  flash select, active low
- qspi_io_out  out  4  IO[3:0] drive data
- qspi_io_oe  out  4  IO[3:0] output enables
- qspi_io_in  in  4  IO[3:0] sampled data

Behaviour:
- Reset values: qspi_cs_n=1, qspi_sclk=0, qspi_io_oe=0, qspi_io_out=0, ack_a=0, ack_b=0, rdata=0, busy=0, last_grant=B, state=IDLE.
- States: IDLE -> CMD (2 nibbles) -> ADDR (6 nibbles, MSB first) -> DUMMY (DUMMY_CYCLES) -> DATA (2 nibbles, high first) -> DONE -> IDLE.
- DUMMY is skipped when DUMMY_CYCLES=0.
- Nibble timing: each SCLK period is 2 clk cycles.
  - Phase 0: sclk=0; new nibble presented on io_out.
  - Phase 1: sclk=1; flash samples on the rising edge.
  - Read data is captured from qspi_io_in at the clk edge that ends phase 1.
- io_oe:
  - 4'b1111 in CMD/ADDR.
  - 4'b0000 in DUMMY/DATA/DONE/IDLE.
  - io_out=0 whenever oe=0.
- Arbitration happens only in IDLE, on the clk edge where a request is sampled (the accept edge):
  - Only one request high: grant it.
  - Both high: grant the port not in last_grant; last_grant updates on each grant.
  - Alternation under contention is guaranteed; with only A active, A is served back-to-back.
- Address latched at grant; later changes to addr_x are ignored.
- Timing from the accept edge (cycle 0):
  - qspi_cs_n=0 from cycle 1 through cycle 32 (16 SCLK periods with default parameters).
  - Cycle 33 is DONE: cs_n=1, sclk=0, rdata updated, ack of the granted port =1 for exactly that cycle.
  - Cycle 34 is IDLE, where a new request may be sampled.
  - cs_n high time between transactions is >= 2 cycles.
- General latency: 1 + 2*(8+DUMMY_CYCLES+2) cycles from the accept edge to ack.
- Only one ack pulses per transaction; ack_a and ack_b are never high together.
- A requester must keep req high until its ack. If req drops mid-transaction, the transaction still completes and the ack still pulses. A req still high in the DONE cycle is not re-accepted until IDLE.
- Reset mid-transaction: on the next clk all outputs return to reset values. No ack is issued and rdata is unchanged from its last value (0 after reset). The requester must re-request.
- A 24-bit address carries no wrap or overflow handling.

Test Plan:
- Reset, then req_a=1 with addr_a=24'h001234 and flash model byte 8'hA5 -> drive nibbles E,B,0,0,1,2,3,4 on rising SCLK edges; cs_n low cycles 1..32; ack_a=1 at cycle 33 only; rdata=8'hA5.
- req_a and req_b raised in the same cycle after reset (last_grant=B) -> A served first with ack_a at 33; B accepted at cycle 34 with ack_b at cycle 67; rdata holds B's byte after that.
- req_a held continuously for 3 reads with req_b=0 -> three back-to-back transactions; acks at cycles 33, 67, 101; cs_n high exactly 2 cycles between each.
- Assert reset at cycle 15 of a port-B transaction -> next cycle cs_n=1, oe=0, sclk=0, busy=0; no ack_b; a new req_b is later accepted with normal timing.
- DUMMY_CYCLES=0, single req_b with addr_b=24'hFFFFFF -> oe=0 immediately after the last address nibble; ack_b at cycle 21; io_oe never 1 during the data phase.
- Change addr_a after grant (at cycle 5) -> the transmitted address equals the value present at the accept edge.

Source files
------------

// File: rtl/qspi_rom_arbiter.sv
// qspi_rom_arbiter
// Issues single-byte quad-I/O reads (opcode, 24-bit address, dummy, data)
// to an external QSPI flash. Two requesters share the flash. Port A is the
// cartridge-ROM fetch path and port B is the preload/debug path.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   req_a/addr_a/ack_a    : port A request, byte address, one-cycle done pulse
//   req_b/addr_b/ack_b    : port B request, byte address, one-cycle done pulse
//   rdata                 : last byte read; held until the next read completes
//   busy                  : high whenever the sequencer is not idle
//   qspi_sclk, qspi_cs_n  : flash clock and active-low select
//   qspi_io_out/_oe/_in   : IO[3:0] drive data, output enables, sampled data
module qspi_rom_arbiter #(
  parameter logic [7:0] CMD          = 8'hEB,
  parameter int         DUMMY_CYCLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [23:0] addr_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [23:0] addr_b,
  output logic        ack_b,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        qspi_sclk,
  output logic        qspi_cs_n,
  output logic [3:0]  qspi_io_out,
  output logic [3:0]  qspi_io_oe,
  input  logic [3:0]  qspi_io_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
  } state_t;

  localparam bit         HAS_DUMMY  = (DUMMY_CYCLES != 0);
  localparam logic [3:0] DUMMY_LAST = HAS_DUMMY ? 4'(DUMMY_CYCLES - 1) : 4'd0;

  state_t      state;
  logic        phase_reg;   // 0: sclk low, nibble presented; 1: sclk high
  logic [3:0]  cnt_reg;     // nibble / dummy-period counter within a state
  logic [27:0] shift_reg;   // remaining outgoing nibbles, next one in [27:24]
  logic [3:0]  data_hi_reg; // first (high) data nibble
  logic        last_grant;  // 1 = B was granted most recently
  logic        cur_b_reg;   // port owning the current transaction
  logic        pick_b;

  // Under contention, serve the port that was not granted last.
  assign pick_b = req_b & (~req_a | ~last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase_reg   <= 1'b0;
      cnt_reg     <= 4'd0;
      shift_reg   <= 28'd0;
      data_hi_reg <= 4'd0;
      last_grant  <= 1'b1;
      cur_b_reg   <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      rdata       <= 8'd0;
      busy        <= 1'b0;
      qspi_sclk   <= 1'b0;
      qspi_cs_n   <= 1'b1;
      qspi_io_out <= 4'd0;
      qspi_io_oe  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_a | req_b) begin
            cur_b_reg   <= pick_b;
            last_grant  <= pick_b;
            // Opcode high nibble goes out now; the rest queues in the shifter.
            shift_reg   <= {CMD[3:0], (pick_b ? addr_b : addr_a)};
            qspi_io_out <= CMD[7:4];
            qspi_io_oe  <= 4'hF;
            qspi_cs_n   <= 1'b0;
            qspi_sclk   <= 1'b0;
            phase_reg   <= 1'b0;
            cnt_reg     <= 4'd0;
            busy        <= 1'b1;
            state       <= S_CMD;
          end
        end

        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (!phase_reg) begin
            qspi_sclk <= 1'b1;
            phase_reg <= 1'b1;
          end else begin
            // End of an SCLK period: falling edge and advance to next nibble.
            qspi_sclk <= 1'b0;
            phase_reg <= 1'b0;
            case (state)
              S_CMD: begin
                qspi_io_out <= shift_reg[27:24];
                shift_reg   <= {shift_reg[23:0], 4'h0};
                if (cnt_reg == 4'd1) begin
                  cnt_reg <= 4'd0;
                  state   <= S_ADDR;
                end else begin
                  cnt_reg <= cnt_reg + 4'd1;
                end
              end
              S_ADDR: begin
                if (cnt_reg == 4'd5) begin
                  // Last address nibble done: release the bus.
                  cnt_reg     <= 4'd0;
                  qspi_io_oe  <= 4'h0;
                  qspi_io_out <= 4'h0;
                  state       <= HAS_DUMMY ? S_DUMMY : S_DATA;
                end else begin
                  cnt_reg     <= cnt_reg + 4'd1;
                  qspi_io_out <= shift_reg[27:24];
                  shift_reg   <= {shift_reg[23:0], 4'h0};
                end
              end
              S_DUMMY: begin
                if (cnt_reg == DUMMY_LAST) begin
                  cnt_reg <= 4'd0;
                  state   <= S_DATA;
                end else begin
                  cnt_reg <= cnt_reg + 4'd1;
                end
              end
              default: begin // S_DATA
                if (cnt_reg == 4'd0) begin
                  data_hi_reg <= qspi_io_in;
                  cnt_reg     <= 4'd1;
                end else begin
                  rdata     <= {data_hi_reg, qspi_io_in};
                  ack_a     <= ~cur_b_reg;
                  ack_b     <= cur_b_reg;
                  qspi_cs_n <= 1'b1;
                  cnt_reg   <= 4'd0;
                  state     <= S_DONE;
                end
              end
            endcase
          end
        end

        S_DONE: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_rom_arbiter.sv
// Directed testbench for qspi_rom_arbiter. A default-parameter instance
// covers arbitration, timing, reset and address latching; a second instance
// with no dummy cycles covers the shortened frame. A small flash model per
// instance records transmitted nibbles and returns byte = addr[7:0] ^ 8'h91.
module tb_qspi_rom_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Default instance (6 dummy cycles)
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [23:0] addr_a = 24'd0, addr_b = 24'd0;
  logic        ack_a, ack_b, busy, sclk, cs_n;
  logic [7:0]  rdata;
  logic [3:0]  io_out, io_oe;
  logic [3:0]  io_in = 4'h0;

  // Zero-dummy instance
  logic        z_req_a = 1'b0, z_req_b = 1'b0;
  logic [23:0] z_addr_a = 24'd0, z_addr_b = 24'd0;
  logic        z_ack_a, z_ack_b, z_busy, z_sclk, z_cs_n;
  logic [7:0]  z_rdata;
  logic [3:0]  z_io_out, z_io_oe;
  logic [3:0]  z_io_in = 4'h0;

  qspi_rom_arbiter #(.CMD(8'hEB), .DUMMY_CYCLES(6)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .ack_b(ack_b),
    .rdata(rdata), .busy(busy),
    .qspi_sclk(sclk), .qspi_cs_n(cs_n),
    .qspi_io_out(io_out), .qspi_io_oe(io_oe), .qspi_io_in(io_in)
  );

  qspi_rom_arbiter #(.CMD(8'hEB), .DUMMY_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_a(z_req_a), .addr_a(z_addr_a), .ack_a(z_ack_a),
    .req_b(z_req_b), .addr_b(z_addr_b), .ack_b(z_ack_b),
    .rdata(z_rdata), .busy(z_busy),
    .qspi_sclk(z_sclk), .qspi_cs_n(z_cs_n),
    .qspi_io_out(z_io_out), .qspi_io_oe(z_io_oe), .qspi_io_in(z_io_in)
  );

  // Flash models, evaluated mid-cycle. sclk is high for exactly one clk
  // cycle per SCLK period, so each high sample is one rising edge.
  int          k1 = 0, kz = 0;
  logic [31:0] cap1 = 32'd0, capz = 32'd0;
  logic [7:0]  fb1 = 8'd0, fbz = 8'd0;
  int          oe_bad1 = 0, oe_badz = 0;

  always @(negedge clk) begin
    if (cs_n) begin
      k1 = 0;
    end else begin
      if (k1 >= 8 && io_oe != 4'h0) oe_bad1++;
      if (sclk) begin
        if (k1 == 0) cap1 = 32'd0;
        if (io_oe == 4'hF) cap1 = {cap1[27:0], io_out};
        if (k1 == 8 + 6) begin
          fb1   = cap1[7:0] ^ 8'h91;
          io_in = fb1[7:4];
        end else if (k1 == 9 + 6) begin
          io_in = fb1[3:0];
        end
        k1++;
      end
    end
  end

  always @(negedge clk) begin
    if (z_cs_n) begin
      kz = 0;
    end else begin
      if (kz >= 8 && z_io_oe != 4'h0) oe_badz++;
      if (z_sclk) begin
        if (kz == 0) capz = 32'd0;
        if (z_io_oe == 4'hF) capz = {capz[27:0], z_io_out};
        if (kz == 8) begin
          fbz     = capz[7:0] ^ 8'h91;
          z_io_in = fbz[7:4];
        end else if (kz == 9) begin
          z_io_in = fbz[3:0];
        end
        kz++;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Per-test observation records for the default instance
  int         ack_a_q[$], ack_b_q[$], fall_q[$], rise_q[$];
  int         both_hi;
  logic [7:0] rd_at_a, rd_at_b;
  logic       prev_cs;

  task automatic clr();
    ack_a_q.delete(); ack_b_q.delete(); fall_q.delete(); rise_q.delete();
    both_hi = 0; rd_at_a = 8'h00; rd_at_b = 8'h00; prev_cs = 1'b1;
  endtask

  // Observe cycles c0..c1 (cycle 1 is the first after the accept edge).
  task automatic watch(input int c0, input int c1, input bit drop);
    for (int c = c0; c <= c1; c++) begin
      @(posedge clk); #1;
      if (!cs_n && prev_cs) fall_q.push_back(c);
      if (cs_n && !prev_cs) rise_q.push_back(c);
      prev_cs = cs_n;
      if (ack_a && ack_b) both_hi++;
      if (ack_a) begin ack_a_q.push_back(c); rd_at_a = rdata; if (drop) req_a = 1'b0; end
      if (ack_b) begin ack_b_q.push_back(c); rd_at_b = rdata; if (drop) req_b = 1'b0; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int z_ack_cyc, z_ack_a_seen, oe_before;

  initial begin
    clr();
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst cs_n/sclk", {30'd0, cs_n, sclk}, 32'h2);
    chk("rst oe/out", {24'd0, io_oe, io_out}, 32'h0);
    chk("rst acks/busy", {29'd0, ack_a, ack_b, busy}, 32'h0);
    chk("rst rdata", {24'd0, rdata}, 32'h0);
    reset = 1'b0;

    // T1: single port-A read
    @(posedge clk); #1;
    clr(); addr_a = 24'h001234; req_a = 1'b1;
    watch(1, 34, 1'b1);
    chk("t1 nibbles", cap1, 32'hEB001234);
    chk("t1 cs fall", fall_q.size() == 1 ? fall_q[0] : -1, 1);
    chk("t1 cs rise", rise_q.size() == 1 ? rise_q[0] : -1, 33);
    chk("t1 ack_a cyc", ack_a_q.size() == 1 ? ack_a_q[0] : -1, 33);
    chk("t1 no ack_b", ack_b_q.size(), 0);
    chk("t1 rdata", {24'd0, rd_at_a}, 32'hA5);

    // T2: simultaneous requests after reset: A first, then B
    do_reset();
    @(posedge clk); #1;
    clr(); addr_a = 24'h000011; addr_b = 24'h00ABCD; req_a = 1'b1; req_b = 1'b1;
    watch(1, 67, 1'b1);
    chk("t2 ack_a cyc", ack_a_q.size() == 1 ? ack_a_q[0] : -1, 33);
    chk("t2 ack_b cyc", ack_b_q.size() == 1 ? ack_b_q[0] : -1, 67);
    chk("t2 B cs fall", fall_q.size() == 2 ? fall_q[1] : -1, 35);
    chk("t2 rdata A", {24'd0, rd_at_a}, 32'h80);
    chk("t2 rdata B", {24'd0, rd_at_b}, 32'h5C);
    chk("t2 nibbles B", cap1, 32'hEB00ABCD);
    chk("t2 acks exclusive", both_hi, 0);
    @(posedge clk); #1;
    chk("t2 rdata held", {24'd0, rdata}, 32'h5C);

    // T3: port A held for three back-to-back reads
    clr(); addr_a = 24'h000100; req_a = 1'b1;
    watch(1, 101, 1'b0);
    req_a = 1'b0;
    chk("t3 ack count", ack_a_q.size(), 3);
    chk("t3 ack 1", ack_a_q.size() == 3 ? ack_a_q[0] : -1, 33);
    chk("t3 ack 2", ack_a_q.size() == 3 ? ack_a_q[1] : -1, 67);
    chk("t3 ack 3", ack_a_q.size() == 3 ? ack_a_q[2] : -1, 101);
    chk("t3 gap 1", (fall_q.size() == 3 && rise_q.size() >= 2) ? fall_q[1] - rise_q[0] : -1, 2);
    chk("t3 gap 2", (fall_q.size() == 3 && rise_q.size() >= 2) ? fall_q[2] - rise_q[1] : -1, 2);
    chk("t3 rdata", {24'd0, rd_at_a}, 32'h91);

    // T4: reset at cycle 15 of a port-B read, then re-request
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr(); addr_b = 24'h000077; req_b = 1'b1;
    watch(1, 15, 1'b0);
    chk("t4 busy mid", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t4 cs_n/sclk", {30'd0, cs_n, sclk}, 32'h2);
    chk("t4 oe", {28'd0, io_oe}, 32'h0);
    chk("t4 busy/ack", {29'd0, busy, ack_a, ack_b}, 32'h0);
    chk("t4 rdata", {24'd0, rdata}, 32'h0);
    chk("t4 no ack_b", ack_b_q.size(), 0);
    reset = 1'b0;
    clr();
    watch(1, 34, 1'b1);
    chk("t4 re cs fall", fall_q.size() == 1 ? fall_q[0] : -1, 1);
    chk("t4 re ack_b", ack_b_q.size() == 1 ? ack_b_q[0] : -1, 33);
    chk("t4 re rdata", {24'd0, rd_at_b}, 32'hE6);

    // T6: address change after grant is ignored
    @(posedge clk); #1;
    clr(); addr_a = 24'h00C3C3; req_a = 1'b1;
    watch(1, 5, 1'b1);
    addr_a = 24'hFFFFFF;
    watch(6, 34, 1'b1);
    chk("t6 nibbles", cap1, 32'hEB00C3C3);
    chk("t6 ack_a cyc", ack_a_q.size() == 1 ? ack_a_q[0] : -1, 33);
    chk("t6 rdata", {24'd0, rd_at_a}, 32'h52);
    chk("t6 oe in data", oe_bad1, 0);

    // T5: zero dummy cycles, port B at the top address
    @(posedge clk); #1;
    oe_before = oe_badz; z_ack_cyc = -1; z_ack_a_seen = 0;
    z_addr_b = 24'hFFFFFF; z_req_b = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      if (c == 16) chk("t5 oe last addr", {28'd0, z_io_oe}, 32'hF);
      if (c == 17) chk("t5 oe after addr", {28'd0, z_io_oe}, 32'h0);
      if (c == 20) chk("t5 cs_n c20", {31'd0, z_cs_n}, 32'h0);
      if (z_ack_a) z_ack_a_seen++;
      if (z_ack_b && z_ack_cyc < 0) begin z_ack_cyc = c; z_req_b = 1'b0; end
    end
    chk("t5 ack_b cyc", z_ack_cyc, 21);
    chk("t5 nibbles", capz, 32'hEBFFFFFF);
    chk("t5 rdata", {24'd0, z_rdata}, 32'h6E);
    chk("t5 oe in data", oe_badz - oe_before, 0);
    chk("t5 no ack_a", z_ack_a_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
